// File: rtl/wb_master_blk_if.sv
// wb_master_blk_if: WISHBONE classic bus between the block-transfer master and the interconnect.
// Latency: none, wires only.
// Backpressure: the slave stalls a beat by withholding ack/err/rty.
interface wb_master_blk_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dout;
  logic [DW-1:0]   din;
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dout, cyc, stb, we, sel,
    input  din, ack, err, rty
  );

  modport slave (
    input  adr, dout, cyc, stb, we, sel,
    output din, ack, err, rty
  );
endinterface

// File: rtl/wb_master_blk.sv
// wb_master_blk: block-transfer WISHBONE master, runs a burst as back-to-back classic single-beat cycles.
// Latency: strobe 1 cycle after read accept (after first word for writes); min beat 2 cycles; done 1 cycle after last beat.
// Backpressure: cmd_ready only in IDLE; wr_valid/rd_ready low stalls in FETCH/HOLD with cyc low.
// Optional: define WB_MBLK_TIMEOUT_EN for a BUS watchdog of TIMEOUT cycles reporting status 3.
module wb_master_blk #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_RETRY = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DW-1:0]     wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DW-1:0]     rd_data,
  output logic              done,
  output logic [1:0]        status,
  wb_master_blk_if.master   wb
);

  localparam int SW = DW / 8;
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_ERR   = 2'd1;
  localparam logic [1:0] ST_RETRY = 2'd2;
  localparam logic [1:0] ST_TMO   = 2'd3;

  typedef enum logic [2:0] {IDLE, FETCH, BUS, HOLD, BACKOFF, DONE} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    adr_q;
  logic [DW-1:0]    dout_q;
  logic [SW-1:0]    sel_q;
  logic             we_q;
  logic             cyc_q;
  logic             done_q;
  logic [1:0]       status_q;
  logic [DW-1:0]    rd_data_q;
  logic [LEN_W-1:0] rem_q;
  logic [RW-1:0]    rty_cnt_q;

  logic accept;
  logic wr_take;
  logic ack_hit;
  logic err_hit;
  logic rty_hit;
  logic rty_abort;
  logic tmo_hit;
  logic tmo_expired;
  logic last_word;

  // Words left counts the beat in flight, so 1 means this ack finishes the burst.
  assign last_word = (rem_q == LEN_W'(1));

`ifdef WB_MBLK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT - 1));

  // Watchdog: counts consecutive unterminated BUS cycles, cleared on any exit from BUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == BUS && state_d == BUS) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo_expired    = 1'b0;
`endif

  // Next-state decode plus one-hot event strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    wr_take   = 1'b0;
    ack_hit   = 1'b0;
    err_hit   = 1'b0;
    rty_hit   = 1'b0;
    rty_abort = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_len == '0) state_d = DONE;
          else if (cmd_we)   state_d = FETCH;
          else               state_d = BUS;
        end
      end
      FETCH: begin
        if (wr_valid) begin
          wr_take = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // err wins over ack, ack wins over rty.
        if (wb.err) begin
          err_hit = 1'b1;
          state_d = DONE;
        end else if (wb.ack) begin
          ack_hit = 1'b1;
          if (!we_q)          state_d = HOLD;
          else if (last_word) state_d = DONE;
          else                state_d = FETCH;
        end else if (wb.rty) begin
          rty_hit = 1'b1;
          if (rty_cnt_q == RW'(MAX_RETRY - 1)) begin
            rty_abort = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = BACKOFF;
          end
        end else if (tmo_expired) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      HOLD: begin
        if (rd_ready) state_d = (rem_q == '0) ? DONE : BUS;
      end
      BACKOFF: state_d = BUS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Registered bus outputs, burst bookkeeping and completion status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q     <= '0;
      dout_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      rd_data_q <= '0;
      rem_q     <= '0;
      rty_cnt_q <= '0;
    end else begin
      cyc_q  <= (state_d == BUS);
      done_q <= (state_d == DONE);
      if (accept) begin
        adr_q     <= cmd_addr;
        sel_q     <= cmd_sel;
        we_q      <= cmd_we;
        rem_q     <= cmd_len;
        rty_cnt_q <= '0;
        status_q  <= ST_OK;
      end
      if (wr_take) dout_q <= wr_data;
      if (ack_hit) begin
        rty_cnt_q <= '0;
        rem_q     <= rem_q - 1'b1;
        adr_q     <= adr_q + AW'(SW);
        if (!we_q) rd_data_q <= wb.din;
      end
      if (rty_hit)   rty_cnt_q <= rty_cnt_q + 1'b1;
      if (rty_abort) status_q  <= ST_RETRY;
      if (err_hit)   status_q  <= ST_ERR;
      if (tmo_hit)   status_q  <= ST_TMO;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == FETCH);
  assign rd_valid  = (state_q == HOLD);
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign status    = status_q;

  assign wb.adr  = adr_q;
  assign wb.dout = dout_q;
  assign wb.sel  = sel_q;
  assign wb.we   = we_q;
  assign wb.cyc  = cyc_q;
  assign wb.stb  = cyc_q;

endmodule

// File: tb/tb_wb_master_blk.sv
// tb_wb_master_blk: directed bench for wb_master_blk with a behavioural WISHBONE slave and stream endpoints.
// Latency: n/a.
// Backpressure: rd_ready driven low, high or toggling per test; slave wait states, retries, errors and hangs per test.
module tb_wb_master_blk;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [3:0]  cmd_sel;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic [1:0]  status;

  wb_master_blk_if #(.AW(32), .DW(32)) wb ();

  wb_master_blk #(
    .AW(32), .DW(32), .LEN_W(16), .MAX_RETRY(4), .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_sel   (cmd_sel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .done      (done),
    .status    (status),
    .wb        (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus controls, written only by the main process.
  int          cmd_id     = 0;
  int          s_wait     = 0;
  int          s_rty      = 0;
  int          s_err_beat = -1;
  logic        s_hang     = 1'b0;
  int          rd_mode    = 1;
  logic [31:0] wbuf [0:63];
  int          w_tail     = 0;

  // Observations, written only by the monitor/slave process.
  logic [31:0] mem [0:255];
  logic [31:0] ack_q  [$];
  logic [31:0] rd_q   [$];
  logic [31:0] sadr_q [$];
  int          gap_q  [$];
  int          done_cnt  = 0;
  int          stb_cyc   = 0;
  int          hold_viol = 0;
  logic [3:0]  last_sel  = 4'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we_i, input logic [31:0] a, input logic [15:0] l, input logic [3:0] s);
    cmd_id++;
    cmd_we    = we_i;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_sel   = s;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Slave, stream endpoints and monitors; everything here runs on the falling edge.
  initial begin
    int          seen_id;
    int          beat;
    int          rty_left;
    int          wait_cnt;
    int          w_head;
    logic        w_fire;
    logic        prev_stb;
    int          gap;
    logic [7:0]  idx;
    seen_id  = 0;
    beat     = 0;
    rty_left = 0;
    wait_cnt = 0;
    w_head   = 0;
    w_fire   = 1'b0;
    prev_stb = 1'b0;
    gap      = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0; wb.din = 32'h0;
    wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (w_fire) w_head++;
      wr_valid = (w_head < w_tail);
      wr_data  = wbuf[w_head % 64];
      w_fire   = wr_valid && wr_ready;

      case (rd_mode)
        0:       rd_ready = 1'b0;
        1:       rd_ready = 1'b1;
        default: rd_ready = !rd_ready;
      endcase
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
      if (rd_valid && wb.cyc) hold_viol++;
      if (done) done_cnt++;
      if (wb.stb) stb_cyc++;
      if (wb.stb && !prev_stb) begin
        sadr_q.push_back(wb.adr);
        gap_q.push_back(gap);
        gap = 0;
      end else if (!wb.stb) begin
        gap++;
      end
      prev_stb = wb.stb;

      if (cmd_id != seen_id) begin
        seen_id  = cmd_id;
        beat     = 0;
        rty_left = s_rty;
        wait_cnt = 0;
      end
      wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0;
      if (wb.cyc && wb.stb && !s_hang) begin
        if (wait_cnt < s_wait) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          idx = wb.adr[9:2];
          if (beat == s_err_beat) begin
            wb.err = 1'b1;
            wb.ack = 1'b1;
          end else if (rty_left > 0) begin
            wb.rty = 1'b1;
            rty_left--;
          end else begin
            wb.ack = 1'b1;
            ack_q.push_back(wb.adr);
            last_sel = wb.sel;
            beat++;
            if (wb.we) mem[idx] = wb.dout;
            else       wb.din   = mem[idx];
          end
        end
      end
    end
  end

  initial begin
    int d0, s0, r0, a0, c0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_len = 16'h0; cmd_sel = 4'h0;
    idle_cycles(3);

    // Reset state.
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_cyc",       64'(wb.cyc),    64'd0);
    chk("rst_stb",       64'(wb.stb),    64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_status",    64'(status),    64'd0);
    chk("rst_adr",       64'(wb.adr),    64'd0);
    chk("rst_rd_valid",  64'(rd_valid),  64'd0);
    chk("rst_wr_ready",  64'(wr_ready),  64'd0);
    chk("rst_rd_data",   64'(rd_data),   64'd0);
    rst = 1'b1;
    idle_cycles(2);

    // Write burst, one wait state per beat.
    for (int i = 0; i < 4; i++) begin wbuf[w_tail % 64] = 32'hA0 + 32'(i); w_tail++; end
    s_wait = 1; d0 = done_cnt; a0 = ack_q.size();
    issue(1'b1, 32'h100, 16'd4, 4'hF);
    wait_done("wr_done", 60);
    chk("wr_status", 64'(status), 64'd0);
    idle_cycles(3);
    chk("wr_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("wr_beats", 64'(ack_q.size() - a0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_adr", 64'(ack_q[a0 + i]), 64'(32'h100 + 32'(4 * i)));
      chk("wr_mem", 64'(mem[64 + i]), 64'(32'hA0 + 32'(i)));
    end
    chk("wr_sel", 64'(last_sel), 64'hF);

    // Read back with rd_ready toggling.
    s_wait = 0; rd_mode = 2; r0 = rd_q.size(); c0 = hold_viol;
    issue(1'b0, 32'h100, 16'd4, 4'hF);
    wait_done("rdt_done", 80);
    chk("rdt_status", 64'(status), 64'd0);
    chk("rdt_count", 64'(rd_q.size() - r0), 64'd4);
    for (int i = 0; i < 4; i++) chk("rdt_data", 64'(rd_q[r0 + i]), 64'(32'hA0 + 32'(i)));
    chk("rdt_hold_cyc_low", 64'(hold_viol - c0), 64'd0);
    rd_mode = 1;
    idle_cycles(2);

    // Single-word read, zero-wait ack: stb, rd_valid, done on successive cycles.
    issue(1'b0, 32'h108, 16'd1, 4'hF);
    chk("rd1_stb_c1", 64'(wb.stb), 64'd1);
    idle_cycles(1);
    chk("rd1_rdv_c2", 64'(rd_valid), 64'd1);
    chk("rd1_cyc_c2", 64'(wb.cyc), 64'd0);
    chk("rd1_data",   64'(rd_data), 64'hA2);
    idle_cycles(1);
    chk("rd1_done_c3", 64'(done), 64'd1);
    idle_cycles(2);

    // Three retries then ack.
    s_rty = 3; s0 = sadr_q.size(); r0 = rd_q.size();
    issue(1'b0, 32'h104, 16'd1, 4'hF);
    wait_done("rty3_done", 40);
    chk("rty3_status", 64'(status), 64'd0);
    chk("rty3_strobes", 64'(sadr_q.size() - s0), 64'd4);
    for (int i = 1; i < 4; i++) begin
      chk("rty3_adr", 64'(sadr_q[s0 + i]), 64'h104);
      chk("rty3_gap", 64'(gap_q[s0 + i]), 64'd1);
    end
    chk("rty3_data", 64'(rd_q[r0]), 64'hA1);
    idle_cycles(2);

    // Four retries exhaust the budget.
    s_rty = 4; s0 = sadr_q.size(); r0 = rd_q.size();
    issue(1'b0, 32'h104, 16'd1, 4'hF);
    wait_done("rty4_done", 40);
    chk("rty4_status", 64'(status), 64'd2);
    chk("rty4_strobes", 64'(sadr_q.size() - s0), 64'd4);
    chk("rty4_no_rd", 64'(rd_q.size() - r0), 64'd0);
    s_rty = 0;
    idle_cycles(2);

    // Zero-length command: done right after accept, status cleared, no strobe.
    s0 = sadr_q.size(); d0 = done_cnt;
    issue(1'b0, 32'h200, 16'd0, 4'hF);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_status", 64'(status), 64'd0);
    idle_cycles(1);
    chk("len0_done_low", 64'(done), 64'd0);
    chk("len0_ready", 64'(cmd_ready), 64'd1);
    idle_cycles(2);
    chk("len0_no_stb", 64'(sadr_q.size() - s0), 64'd0);
    chk("len0_pulses", 64'(done_cnt - d0), 64'd1);

    // err together with ack on the second word of five.
    s_err_beat = 1; s0 = sadr_q.size(); r0 = rd_q.size();
    issue(1'b0, 32'h100, 16'd5, 4'hF);
    wait_done("err_done", 40);
    chk("err_status", 64'(status), 64'd1);
    idle_cycles(5);
    chk("err_strobes", 64'(sadr_q.size() - s0), 64'd2);
    chk("err_rd_count", 64'(rd_q.size() - r0), 64'd1);
    chk("err_rd_word0", 64'(rd_q[r0]), 64'hA0);
    s_err_beat = -1;

    // Address wraps past the top of the space.
    for (int i = 0; i < 2; i++) begin wbuf[w_tail % 64] = 32'hB0 + 32'(i); w_tail++; end
    a0 = ack_q.size();
    issue(1'b1, 32'hFFFF_FFFC, 16'd2, 4'h3);
    wait_done("wrap_done", 40);
    chk("wrap_adr0", 64'(ack_q[a0]), 64'hFFFF_FFFC);
    chk("wrap_adr1", 64'(ack_q[a0 + 1]), 64'h0);
    chk("wrap_sel", 64'(last_sel), 64'h3);
    idle_cycles(2);

    // Reset pulled while strobing.
    s_hang = 1'b1; d0 = done_cnt;
    issue(1'b0, 32'h100, 16'd1, 4'hF);
    chk("arst_stb_before", 64'(wb.stb), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc", 64'(wb.cyc), 64'd0);
    chk("arst_stb", 64'(wb.stb), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycles(2);
    chk("arst_ready", 64'(cmd_ready), 64'd1);
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

`ifdef WB_MBLK_TIMEOUT_EN
    // Silent slave trips the watchdog after 16 strobe cycles.
    c0 = stb_cyc;
    issue(1'b0, 32'h100, 16'd1, 4'hF);
    wait_done("tmo_done", 100);
    chk("tmo_status", 64'(status), 64'd3);
    chk("tmo_stb_cycles", 64'(stb_cyc - c0), 64'd16);
    s_hang = 1'b0;
`else
    // Silent slave: the master keeps strobing.
    issue(1'b0, 32'h10C, 16'd1, 4'hF);
    idle_cycles(1000);
    chk("hang_stb", 64'(wb.stb), 64'd1);
    s_hang = 1'b0; r0 = rd_q.size();
    wait_done("hang_release_done", 20);
    chk("hang_status", 64'(status), 64'd0);
    chk("hang_data", 64'(rd_q[r0]), 64'hA3);
`endif
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
